// File: rtl/pcseq_pkg.sv
// pcseq_pkg
// Shared definitions for the pc_sequencer slice of the single-cycle MIPS core.
// Contents:
//   pcseq_state_t     - run-control state encoding (RUN / PAUSE / HALT)
//   DEFAULT_RESET_PC  - byte address the PC takes on reset
//   SYSCALL_HALT_CODE - $v0 value that turns a syscall into a permanent halt
//   branch_offset()   - sign-extended, word-scaled branch displacement

package pcseq_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_PAUSE = 2'b01,
        ST_HALT  = 2'b10
    } pcseq_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] SYSCALL_HALT_CODE = 32'd10;

    // A branch immediate counts words, so it is sign-extended and shifted
    // left by two to get a byte displacement relative to pc+4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/npc_select.sv
// npc_select
// Purely combinational next-PC mux for the single-cycle core.
// Ports:
//   pc_plus4     in  32  sequential successor of the current PC
//   jr,jal,j     in  1   jump strobes from the decoder
//   beq,bne      in  1   branch strobes from the decoder
//   equal        in  1   ALU rs==rt flag
//   rs_data      in  32  jr target
//   target26     in  26  jump target field of the instruction
//   imm16        in  16  branch immediate of the instruction
//   next_pc      out 32  selected next PC (jr > j/jal > taken branch > pc+4)
//   jump_taken   out 1   a jump of any kind was selected
//   branch_taken out 1   a conditional branch was selected (no jump pending)

module npc_select
    import pcseq_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        jr,
    input  logic        jal,
    input  logic        j,
    input  logic        beq,
    input  logic        bne,
    input  logic        equal,
    input  logic [31:0] rs_data,
    input  logic [25:0] target26,
    input  logic [15:0] imm16,
    output logic [31:0] next_pc,
    output logic        jump_taken,
    output logic        branch_taken
);

    logic branch_cond;

    assign branch_cond  = (beq & equal) | (bne & ~equal);
    assign jump_taken   = jr | j | jal;
    assign branch_taken = branch_cond & ~jump_taken;

    // Priority mux. The jr target drops its low two bits so the PC always
    // stays word aligned; the top module flags the misalignment separately.
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = {rs_data[31:2], 2'b00};
        end else if (j || jal) begin
            next_pc = {pc_plus4[31:28], target26, 2'b00};
        end else if (branch_cond) begin
            next_pc = pc_plus4 + branch_offset(imm16);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Next-PC and run-control unit for the single-cycle MIPS FPGA core. Holds the
// PC register, the RUN/PAUSE/HALT sequencer driven by syscall, and the sticky
// jr misalignment flag. All state advances only on cycles with en=1.
// Optional feature macro: PCSEQ_STATS_EN adds saturating statistics counters
// (cyc_cnt, jmp_cnt, br_cnt) and their ports.
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   en                         step enable from the FPGA clock divider
//   go                         resume pulse, only looked at while paused
//   jr,jal,j,beq,bne,syscall   decoder strobes for the current instruction
//   equal                      ALU rs==rt flag
//   rs_data, v0_data           jr target and $v0 value
//   instr                      current instruction (imm16, target26)
//   pc, pc_plus4, imem_addr    current PC, link value, ROM word address
//   halted, paused, misalign   status flags
//   cyc_cnt, jmp_cnt, br_cnt   statistics (PCSEQ_STATS_EN only)

module pc_sequencer
    import pcseq_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_CODE = SYSCALL_HALT_CODE,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             go,
    input  logic             jr,
    input  logic             jal,
    input  logic             j,
    input  logic             beq,
    input  logic             bne,
    input  logic             syscall,
    input  logic             equal,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      v0_data,
    input  logic [31:0]      instr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [9:0]       imem_addr,
    output logic             halted,
    output logic             paused,
    output logic             misalign
`ifdef PCSEQ_STATS_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] jmp_cnt,
    output logic [CNT_W-1:0] br_cnt
`endif
);

    pcseq_state_t state_q, state_d;
    logic [31:0]  pc_d;
    logic         misalign_d;
    logic [31:0]  npc;
    logic         jump_taken;
    logic         branch_taken;
    logic         unused_opcode;

    // Opcode/function bits belong to the decoder, not to us.
    assign unused_opcode = ^instr[31:26];

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc[11:2];
    assign paused    = (state_q == ST_PAUSE);
    assign halted    = (state_q == ST_HALT);

    npc_select u_npc (
        .pc_plus4     (pc_plus4),
        .jr           (jr),
        .jal          (jal),
        .j            (j),
        .beq          (beq),
        .bne          (bne),
        .equal        (equal),
        .rs_data      (rs_data),
        .target26     (instr[25:0]),
        .imm16        (instr[15:0]),
        .next_pc      (npc),
        .jump_taken   (jump_taken),
        .branch_taken (branch_taken)
    );

    // Next-state logic. A syscall overrides any jump/branch strobe in the
    // same instruction. Pausing already steps past the syscall so that go
    // resumes at the following instruction; halting leaves pc on the syscall.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        misalign_d = misalign;
        if (en) begin
            case (state_q)
                ST_RUN: begin
                    if (syscall) begin
                        if (v0_data == HALT_CODE) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_PAUSE;
                            pc_d    = pc_plus4;
                        end
                    end else begin
                        pc_d = npc;
                        if (jr && (rs_data[1:0] != 2'b00)) begin
                            misalign_d = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (go) begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State, PC and sticky misalignment registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc       <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc       <= pc_d;
            misalign <= misalign_d;
        end
    end

`ifdef PCSEQ_STATS_EN
    logic run_step;
    logic instr_step;

    assign run_step   = en && (state_q == ST_RUN);
    assign instr_step = run_step && !syscall;

    // Statistics counters stick at all-ones instead of wrapping so a long
    // run never reports a misleadingly small count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            jmp_cnt <= '0;
            br_cnt  <= '0;
        end else begin
            if (run_step && (cyc_cnt != '1)) begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
            if (instr_step && jump_taken && (jmp_cnt != '1)) begin
                jmp_cnt <= jmp_cnt + CNT_W'(1);
            end
            if (instr_step && branch_taken && (br_cnt != '1)) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_stats;
    localparam int unused_cnt_w = CNT_W;
    assign unused_stats = jump_taken ^ branch_taken;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: a table of directed vectors, hand
// sequences for pause/halt/reset, then randomized cycles against a
// behavioural model. Build with +define+PCSEQ_STATS_EN to cover counters.

module tb_pc_sequencer;

    typedef struct {
        logic        en, go, jr, jal, j, beq, bne, syscall, equal;
        logic [31:0] rs, v0, instr;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, go, jr, jal, j, beq, bne, syscall, equal;
    logic [31:0] rs_data, v0_data, instr;
    logic [31:0] pc, pc_plus4;
    logic [9:0]  imem_addr;
    logic        halted, paused, misalign;
`ifdef PCSEQ_STATS_EN
    logic [31:0] cyc_cnt, jmp_cnt, br_cnt;
`endif

    int checks = 0;
    int failures = 0;

    stim_t       cur;
    logic [31:0] m_pc;
    bit          m_paused, m_halted, m_mis;
    logic [31:0] m_cyc, m_jmp, m_br;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .go        (go),
        .jr        (jr),
        .jal       (jal),
        .j         (j),
        .beq       (beq),
        .bne       (bne),
        .syscall   (syscall),
        .equal     (equal),
        .rs_data   (rs_data),
        .v0_data   (v0_data),
        .instr     (instr),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .imem_addr (imem_addr),
        .halted    (halted),
        .paused    (paused),
        .misalign  (misalign)
`ifdef PCSEQ_STATS_EN
        ,
        .cyc_cnt   (cyc_cnt),
        .jmp_cnt   (jmp_cnt),
        .br_cnt    (br_cnt)
`endif
    );

    function automatic stim_t mk(input bit e, input bit g, input bit r, input bit jl,
                                 input bit jj, input bit bq, input bit bn, input bit sc,
                                 input bit eq, input logic [31:0] rs, input logic [31:0] v0,
                                 input logic [31:0] ins);
        stim_t s;
        s.en = e; s.go = g; s.jr = r; s.jal = jl; s.j = jj; s.beq = bq; s.bne = bn;
        s.syscall = sc; s.equal = eq; s.rs = rs; s.v0 = v0; s.instr = ins;
        return s;
    endfunction

    function automatic stim_t plain();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    endfunction

    // Reference next PC from the instruction-set rules using plain arithmetic.
    function automatic logic [31:0] modelNext(input logic [31:0] cpc, input stim_t s);
        logic [31:0] seq;
        int          off;
        seq = cpc + 32'd4;
        off = int'($signed(s.instr[15:0]));
        if (s.jr) return s.rs & 32'hFFFF_FFFC;
        if (s.j || s.jal) return (seq & 32'hF000_0000) + ({6'b0, s.instr[25:0]} * 32'd4);
        if ((s.beq && s.equal) || (s.bne && !s.equal)) return seq + 32'(off * 4);
        return seq;
    endfunction

    task automatic modelReset();
        m_pc = 32'h0; m_paused = 0; m_halted = 0; m_mis = 0;
        m_cyc = 0; m_jmp = 0; m_br = 0;
    endtask

    task automatic modelStep();
        if (!rst_n || !cur.en || m_halted) return;
        if (m_paused) begin
            if (cur.go) m_paused = 0;
            return;
        end
        if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
        if (cur.syscall) begin
            if (cur.v0 == 32'd10) m_halted = 1;
            else begin
                m_paused = 1;
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (cur.jr && (cur.rs % 4 != 0)) m_mis = 1;
            if (cur.jr || cur.j || cur.jal) begin
                if (m_jmp != 32'hFFFF_FFFF) m_jmp++;
            end else if ((cur.beq && cur.equal) || (cur.bne && !cur.equal)) begin
                if (m_br != 32'hFFFF_FFFF) m_br++;
            end
            m_pc = modelNext(m_pc, cur);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        cur = s;
        en = s.en; go = s.go; jr = s.jr; jal = s.jal; j = s.j; beq = s.beq; bne = s.bne;
        syscall = s.syscall; equal = s.equal; rs_data = s.rs; v0_data = s.v0; instr = s.instr;
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " pc"}, pc, m_pc);
        checkOutput({tag, " pc_plus4"}, pc_plus4, m_pc + 32'd4);
        checkOutput({tag, " imem_addr"}, {22'b0, imem_addr}, (m_pc / 4) % 1024);
        checkOutput({tag, " paused"}, {31'b0, paused}, {31'b0, m_paused});
        checkOutput({tag, " halted"}, {31'b0, halted}, {31'b0, m_halted});
        checkOutput({tag, " misalign"}, {31'b0, misalign}, {31'b0, m_mis});
`ifdef PCSEQ_STATS_EN
        checkOutput({tag, " cyc_cnt"}, cyc_cnt, m_cyc);
        checkOutput({tag, " jmp_cnt"}, jmp_cnt, m_jmp);
        checkOutput({tag, " br_cnt"}, br_cnt, m_br);
`endif
    endtask

    initial begin
        vec_t        vecs[19];
        logic [31:0] prev;
        logic [31:0] saved_cyc;
        stim_t       s;

        rst_n = 1'b0;
        applyStimulus(plain());
        modelReset();
        #12;
        checkModel("reset");

        // Move pc away from zero, then pull reset mid-cycle.
        @(posedge clk); #1; rst_n = 1'b1;
        applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h40, 0, 0));
        tick();
        checkOutput("pre-reset pc", pc, 32'h40);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async reset pc", pc, 32'h0);
        checkModel("async reset");
        @(posedge clk); #1; rst_n = 1'b1;

        vecs[0]  = '{mk(1,0,0,0,0,0,0,0,0, 0, 0, 32'h0),                   32'h0000_0004, 0};
        vecs[1]  = '{mk(1,0,0,0,0,0,0,0,0, 0, 0, 32'h0),                   32'h0000_0008, 0};
        vecs[2]  = '{mk(1,0,1,0,0,0,0,0,0, 32'h10, 0, 32'h0),              32'h0000_0010, 0};
        vecs[3]  = '{mk(1,0,0,0,0,1,0,0,1, 0, 0, 32'h1000_FFFE),           32'h0000_000C, 0};
        vecs[4]  = '{mk(1,0,1,0,0,0,0,0,0, 32'h10, 0, 32'h0),              32'h0000_0010, 0};
        vecs[5]  = '{mk(1,0,0,0,0,1,0,0,0, 0, 0, 32'h1000_FFFE),           32'h0000_0014, 0};
        vecs[6]  = '{mk(1,0,0,0,0,0,1,0,0, 0, 0, 32'h1400_0003),           32'h0000_0024, 0};
        vecs[7]  = '{mk(1,0,0,0,0,0,1,0,1, 0, 0, 32'h1400_0003),           32'h0000_0028, 0};
        vecs[8]  = '{mk(1,0,1,0,0,0,0,0,0, 32'h1000_0000, 0, 0),           32'h1000_0000, 0};
        vecs[9]  = '{mk(1,0,0,1,0,0,0,0,0, 0, 0, 32'h0C00_0040),           32'h1000_0100, 0};
        vecs[10] = '{mk(1,0,0,0,1,0,0,0,0, 0, 0, 32'h0BFF_FFFF),           32'h1FFF_FFFC, 0};
        vecs[11] = '{mk(1,0,0,0,0,0,0,0,0, 0, 0, 32'h0),                   32'h2000_0000, 0};
        vecs[12] = '{mk(1,0,1,0,0,0,0,0,0, 32'hFFFF_FFFC, 0, 0),           32'hFFFF_FFFC, 0};
        vecs[13] = '{mk(1,0,0,0,0,0,0,0,0, 0, 0, 32'h0),                   32'h0000_0000, 0};
        vecs[14] = '{mk(1,0,1,1,0,0,0,0,0, 32'h80, 0, 32'h0C00_0040),      32'h0000_0080, 0};
        vecs[15] = '{mk(1,0,0,0,1,1,0,0,1, 0, 0, 32'h0800_0010),           32'h0000_0040, 0};
        vecs[16] = '{mk(1,0,1,0,0,0,0,0,0, 32'h206, 0, 0),                 32'h0000_0204, 1};
        vecs[17] = '{mk(1,0,0,0,0,0,0,0,0, 0, 0, 32'h0),                   32'h0000_0208, 1};
        vecs[18] = '{mk(1,0,0,0,0,1,0,0,1, 0, 0, 32'h1000_7FFF),           32'h0002_0208, 1};

        prev = 32'h0;
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].s);
            #1;
            checkOutput($sformatf("vec%0d pc_plus4", i), pc_plus4, prev + 32'd4);
            tick();
            checkOutput($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
            checkOutput($sformatf("vec%0d imem_addr", i), {22'b0, imem_addr}, (vecs[i].exp_pc >> 2) & 32'h3FF);
            checkOutput($sformatf("vec%0d misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
            prev = vecs[i].exp_pc;
        end

        // en=0 holds everything even with strobes present.
        s = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h500, 0, 0);
        applyStimulus(s);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("en0 pc", pc, 32'h0002_0208);
        checkModel("en0");

        // Syscall pause at 0x20 with a jump strobe also set.
        applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h20, 0, 0));
        tick();
        applyStimulus(mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 32'd1, 32'h0800_0100));
        tick();
        checkOutput("pause paused", {31'b0, paused}, 32'd1);
        checkOutput("pause pc", pc, 32'h24);
        applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h300, 0, 0));
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("pause frozen pc", pc, 32'h24);
        end
        applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        checkOutput("pause go en0", {31'b0, paused}, 32'd1);
        applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        checkOutput("resume paused", {31'b0, paused}, 32'd0);
        checkOutput("resume pc", pc, 32'h24);
        applyStimulus(plain());
        tick();
        checkOutput("after resume pc", pc, 32'h28);
        checkModel("pause seq");

        // Syscall halt; go pulses are ignored.
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'd10, 0));
        tick();
        checkOutput("halt halted", {31'b0, halted}, 32'd1);
        checkOutput("halt pc", pc, 32'h28);
        saved_cyc = m_cyc;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'd1, 0));
            tick();
            applyStimulus(plain());
            tick();
        end
        checkOutput("halt frozen pc", pc, 32'h28);
        checkOutput("halt still halted", {31'b0, halted}, 32'd1);
`ifdef PCSEQ_STATS_EN
        checkOutput("halt cyc frozen", cyc_cnt, saved_cyc);
`endif
        checkModel("halt seq");
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkModel("reset from halt");
        @(posedge clk); #1; rst_n = 1'b1;

        // Randomized run against the model.
        for (int i = 0; i < 500; i++) begin
            s.en      = ($urandom_range(0, 9) < 8);
            s.go      = ($urandom_range(0, 2) == 0);
            s.jr      = ($urandom_range(0, 7) == 0);
            s.jal     = ($urandom_range(0, 9) == 0);
            s.j       = ($urandom_range(0, 9) == 0);
            s.beq     = ($urandom_range(0, 4) == 0);
            s.bne     = ($urandom_range(0, 4) == 0);
            s.syscall = ($urandom_range(0, 19) == 0);
            s.equal   = $urandom_range(0, 1) == 1;
            s.rs      = $urandom();
            s.v0      = ($urandom_range(0, 3) == 0) ? 32'd10 : 32'($urandom_range(0, 12));
            s.instr   = $urandom();
            applyStimulus(s);
            tick();
            checkModel($sformatf("rand%0d", i));
            if ($urandom_range(0, 39) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                modelReset();
                checkModel("rand reset");
                @(posedge clk); #1; rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
